// File: rtl/pacman_seg_scanner.sv
// pacman_seg_scanner
// Self-timed multiplexed seven-segment scanner for the PacMan board.
// Walks the digits of a common-anode display, lighting each one for
// REFRESH_DIV clocks. It renders the PacMan glyph (top or bottom half-cell,
// four facing directions), a cheese glyph and a blinking game-over pattern.
//
// Position updates from the game FSM go into a pending register. They are
// committed only at the frame boundary, so a frame never shows a half-moved
// PacMan.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   pos_valid    one-cycle strobe, captures pac_pos/pac_dir into pending
//   pac_pos      {row, column}, row 0 = top half, 1 = bottom half
//   pac_dir      0 up, 1 down, 2 left, 3 right
//   cheese_en    cheese present
//   cheese_pos   cheese {row, column}
//   game_over    level, selects blink mode
//   anodes       active-low digit enables (one-hot-low)
//   cathodes     active-low segment pattern
//   digit_idx    digit currently lit
//   frame_tick   one-cycle pulse when digit 0 starts a new frame
//   cheese_eaten one-cycle pulse when the committed position lands on cheese
module pacman_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter int CW           = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pos_valid,
  input  logic [CW:0]           pac_pos,
  input  logic [1:0]            pac_dir,
  input  logic                  cheese_en,
  input  logic [CW:0]           cheese_pos,
  input  logic                  game_over,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [7:0]            cathodes,
  output logic [CW-1:0]         digit_idx,
  output logic                  frame_tick,
  output logic                  cheese_eaten
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_OVER  = 8'b10010011;

  logic [RW-1:0]   refresh_cnt;
  logic            scanning;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;
  logic [CW:0]     pend_pos;
  logic [1:0]      pend_dir;
  logic [CW:0]     com_pos;
  logic [1:0]      com_dir;

  logic            refresh_wrap;
  logic            digit_last;
  logic            boundary;
  logic            pos_ok;
  logic            blink_wrap;
  logic [CW-1:0]   digit_nxt;
  logic [CW:0]     com_pos_nxt;
  logic [1:0]      com_dir_nxt;
  logic            blink_phase_nxt;
  logic [NUM_DIGITS-1:0] anodes_nxt;
  logic [7:0]      cathodes_nxt;
  logic            eaten_nxt;

  // The refresh counter holds for the first clock after reset. That clock
  // only lights digit 0, so digit 0 then stays lit for a full REFRESH_DIV
  // period like every other digit.
  // The frame boundary is the wrap of the last digit. Everything that
  // belongs to the new frame (committed position, blink phase) is computed
  // as its next-state value here. The output registers then render digit 0
  // of the new frame with the new values on that same edge.
  always_comb begin
    refresh_wrap    = scanning && (refresh_cnt == RW'(REFRESH_DIV - 1));
    digit_last      = (digit_idx == CW'(NUM_DIGITS - 1));
    boundary        = refresh_wrap && digit_last;
    digit_nxt       = digit_idx;
    if (refresh_wrap) digit_nxt = digit_last ? '0 : digit_idx + 1'b1;
    com_pos_nxt     = boundary ? pend_pos : com_pos;
    com_dir_nxt     = boundary ? pend_dir : com_dir;
    blink_wrap      = (blink_cnt == BW'(BLINK_FRAMES - 1));
    blink_phase_nxt = (boundary && blink_wrap) ? ~blink_phase : blink_phase;
    pos_ok          = ({1'b0, pac_pos[CW-1:0]} < (CW+1)'(NUM_DIGITS));
    eaten_nxt       = boundary && cheese_en && !game_over && (pend_pos == cheese_pos);
  end

  // Anode strobe: only the digit about to be lit is pulled low.
  always_comb begin
    anodes_nxt = '1;
    anodes_nxt[digit_nxt] = 1'b0;
  end

  // Segment pattern for the digit about to be lit. The checks run in
  // priority order: game-over blink, then the PacMan glyph, then the cheese
  // glyph. PacMan therefore hides cheese that shares its cell.
  always_comb begin
    cathodes_nxt = GLYPH_BLANK;
    if (game_over) begin
      if (blink_phase_nxt) cathodes_nxt = GLYPH_OVER;
    end else if (com_pos_nxt[CW-1:0] == digit_nxt) begin
      if (!com_pos_nxt[CW]) begin
        case (com_dir_nxt)
          DIR_UP:   cathodes_nxt = 8'b10111001;
          DIR_DOWN: cathodes_nxt = 8'b00111011;
          DIR_LEFT: cathodes_nxt = 8'b00111101;
          default:  cathodes_nxt = 8'b01111001;
        endcase
      end else begin
        case (com_dir_nxt)
          DIR_UP:   cathodes_nxt = 8'b11000111;
          DIR_DOWN: cathodes_nxt = 8'b11010101;
          DIR_LEFT: cathodes_nxt = 8'b11001101;
          default:  cathodes_nxt = 8'b11100101;
        endcase
      end
    end else if (cheese_en && (cheese_pos[CW-1:0] == digit_nxt)) begin
      cathodes_nxt = cheese_pos[CW] ? 8'b11110111 : 8'b11111110;
    end
  end

  // Scan timing, blink timing and the pending/committed position registers.
  // At the boundary the committed registers take the old pending value.
  // A strobe on that same edge lands in pending and waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      scanning    <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pend_pos    <= '0;
      pend_dir    <= DIR_RIGHT;
      com_pos     <= '0;
      com_dir     <= DIR_RIGHT;
    end else begin
      scanning <= 1'b1;
      if (scanning) refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
      digit_idx   <= digit_nxt;
      com_pos     <= com_pos_nxt;
      com_dir     <= com_dir_nxt;
      blink_phase <= blink_phase_nxt;
      if (boundary) blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (pos_valid && pos_ok) begin
        pend_pos <= pac_pos;
        pend_dir <= pac_dir;
      end
    end
  end

  // Registered pin drivers. They blank the display immediately on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes       <= '1;
      cathodes     <= GLYPH_BLANK;
      frame_tick   <= 1'b0;
      cheese_eaten <= 1'b0;
    end else begin
      anodes       <= anodes_nxt;
      cathodes     <= cathodes_nxt;
      frame_tick   <= boundary;
      cheese_eaten <= eaten_nxt;
    end
  end

endmodule

// File: tb/tb_pacman_seg_scanner.sv
// tb_pacman_seg_scanner
// Randomised self-checking bench for pacman_seg_scanner.
// The reference model tracks the number of clocks since reset release. From
// that count it derives, with plain division, the lit digit, the frame
// number and the blink phase. A five-digit display is used so that columns
// 5..7 exist as out-of-range positions.
module tb_pacman_seg_scanner;

  localparam int N   = 5;
  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam int CW  = $clog2(N);
  localparam int NUM_CYCLES = 3000;

  localparam logic [7:0] TOP_GLYPH [4] = '{8'b10111001, 8'b00111011, 8'b00111101, 8'b01111001};
  localparam logic [7:0] BOT_GLYPH [4] = '{8'b11000111, 8'b11010101, 8'b11001101, 8'b11100101};

  logic          clk = 1'b0;
  logic          rst;
  logic          pos_valid;
  logic [CW:0]   pac_pos;
  logic [1:0]    pac_dir;
  logic          cheese_en;
  logic [CW:0]   cheese_pos;
  logic          game_over;
  logic [N-1:0]  anodes;
  logic [7:0]    cathodes;
  logic [CW-1:0] digit_idx;
  logic          frame_tick;
  logic          cheese_eaten;

  int errorCount = 0;
  int checkCount = 0;
  int eatCount   = 0;

  // Reference model state
  int          k;
  logic [CW:0] pendPos, comPos;
  logic [1:0]  pendDir, comDir;
  logic [N-1:0] expAnodes;
  logic [7:0]  expCathodes;
  int          expDigit;
  logic        expTick, expEat;

  pacman_seg_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .pos_valid(pos_valid), .pac_pos(pac_pos),
    .pac_dir(pac_dir), .cheese_en(cheese_en), .cheese_pos(cheese_pos),
    .game_over(game_over), .anodes(anodes), .cathodes(cathodes),
    .digit_idx(digit_idx), .frame_tick(frame_tick), .cheese_eaten(cheese_eaten)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, k);
    end
  endtask

  function automatic logic [7:0] expectedGlyph(int digit, int frameNo);
    if (game_over) return (((frameNo / BF) % 2) == 1) ? 8'b10010011 : 8'hFF;
    if (int'(comPos[CW-1:0]) == digit) return comPos[CW] ? BOT_GLYPH[comDir] : TOP_GLYPH[comDir];
    if (cheese_en && int'(cheese_pos[CW-1:0]) == digit) return cheese_pos[CW] ? 8'hF7 : 8'hFE;
    return 8'hFF;
  endfunction

  // Advance the reference model by one clock edge, using the inputs the DUT
  // sampled on that edge.
  task automatic modelStep();
    int period, frameNo;
    logic boundary;
    if (rst) begin
      k = 0;
      pendPos = '0; comPos = '0; pendDir = 2'd3; comDir = 2'd3;
      expAnodes = '1; expCathodes = 8'hFF; expDigit = 0; expTick = 0; expEat = 0;
      return;
    end
    k++;
    boundary = (k > 1) && (((k - 1) % (DIV * N)) == 0);
    if (boundary) begin
      comPos = pendPos;
      comDir = pendDir;
    end
    expEat  = boundary && cheese_en && !game_over && (comPos == cheese_pos);
    expTick = boundary;
    if (pos_valid && int'(pac_pos[CW-1:0]) < N) begin
      pendPos = pac_pos;
      pendDir = pac_dir;
    end
    period   = (k - 1) / DIV;
    expDigit = period % N;
    frameNo  = period / N;
    expAnodes = '1;
    expAnodes[expDigit] = 1'b0;
    expCathodes = expectedGlyph(expDigit, frameNo);
    if (expEat) eatCount++;
  endtask

  task automatic checkAll();
    checkOutput("anodes", 32'(anodes), 32'(expAnodes));
    checkOutput("cathodes", 32'(cathodes), 32'(expCathodes));
    checkOutput("digit_idx", 32'(digit_idx), 32'(expDigit));
    checkOutput("frame_tick", 32'(frame_tick), 32'(expTick));
    checkOutput("cheese_eaten", 32'(cheese_eaten), 32'(expEat));
  endtask

  // Random inputs for one cycle. Cheese is often moved onto the pending
  // PacMan cell so that eat events occur. A short reset pulse lands mid-run.
  task automatic applyStimulus(input int cyc);
    rst = (cyc >= 1500 && cyc < 1502);
    pos_valid = ($urandom_range(0, 9) == 0);
    pac_pos   = (CW+1)'($urandom_range(0, 15));
    pac_dir   = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 79) == 0) cheese_en = ~cheese_en;
    if ($urandom_range(0, 39) == 0)
      cheese_pos = ($urandom_range(0, 1) == 0) ? pendPos : (CW+1)'($urandom_range(0, 15));
    if ($urandom_range(0, 199) == 0) game_over = ~game_over;
  endtask

  initial begin
    rst = 1'b1; pos_valid = 1'b0; pac_pos = '0; pac_dir = 2'd0;
    cheese_en = 1'b0; cheese_pos = '0; game_over = 1'b0;
    repeat (3) begin
      @(posedge clk);
      modelStep();
      #1 checkAll();
    end
    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      applyStimulus(cyc);
      @(posedge clk);
      modelStep();
      #1 checkAll();
    end
    $display("[TB] model cheese_eaten events: %0d", eatCount);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
